pipeline_stall_ctrl: RTL and testbench

- Consumer side of the decode-stage hazard signal: turns hazard/branch/multdiv events into pipeline-latch enables, flushes and bubble inserts for the 5-stage processor.
- Sits between hazard detection, branch resolution in X, and the multdiv unit, and drives the PC, F/D, D/X and X/M latches.
- Owns the multdiv wait handshake and saturating performance counters for stall and flush cycles.

---
 rtl/pipeline_stall_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline latch enable / flush / bubble controller for the 5-stage core.
// Owns the multdiv wait handshake and saturating stall/flush counters.
module pipeline_stall_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             hazard,
    input  logic             branch_taken_x,
    input  logic             md_start_x,
    input  logic             md_ready,
    output logic             pc_en,
    output logic             fd_en,
    output logic             fd_flush,
    output logic             dx_bubble,
    output logic             dx_en,
    output logic             xm_bubble,
    output logic             md_go,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MD_TIMEOUT - 1);

    typedef enum logic {
        RUN,
        MD_WAIT
    } state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              guard, guard_nxt;
    logic              timeout_hit;
    logic              md_take;
    logic              flush_evt;

    // The guard masks md_start_x for the one RUN cycle in which the finished
    // mult/div instruction is still sitting in X.
    always_comb begin
        md_take   = (state == RUN) && md_start_x && !guard;
        flush_evt = (state == RUN) && !md_take && branch_taken_x;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RUN;
            wait_cnt   <= '0;
            guard      <= 1'b0;
            md_timeout <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            guard    <= guard_nxt;
            if (timeout_hit) begin
                md_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        guard_nxt    = 1'b0;
        timeout_hit  = 1'b0;
        case (state)
            RUN: begin
                if (md_take) begin
                    state_nxt    = MD_WAIT;
                    wait_cnt_nxt = '0;
                end
            end
            MD_WAIT: begin
                wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                if (md_ready) begin
                    state_nxt = RUN;
                    guard_nxt = 1'b1;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt   = RUN;
                    guard_nxt   = 1'b1;
                    timeout_hit = 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        pc_en     = 1'b1;
        fd_en     = 1'b1;
        dx_en     = 1'b1;
        fd_flush  = 1'b0;
        dx_bubble = 1'b0;
        xm_bubble = 1'b0;
        md_go     = 1'b0;
        if (!reset_n) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            dx_en     = 1'b0;
            fd_flush  = 1'b1;
            dx_bubble = 1'b1;
            xm_bubble = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (md_take) begin
                        md_go     = 1'b1;
                        pc_en     = 1'b0;
                        fd_en     = 1'b0;
                        dx_en     = 1'b0;
                        xm_bubble = 1'b1;
                    end else if (branch_taken_x) begin
                        fd_flush  = 1'b1;
                        dx_bubble = 1'b1;
                    end else if (hazard) begin
                        pc_en     = 1'b0;
                        fd_en     = 1'b0;
                        dx_bubble = 1'b1;
                    end
                end
                MD_WAIT: begin
                    pc_en     = 1'b0;
                    fd_en     = 1'b0;
                    dx_en     = 1'b0;
                    xm_bubble = !md_ready;
                end
                default: begin
                    pc_en = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_evt && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl (MD_TIMEOUT=8, CNT_W=4).
module tb_pipeline_stall_ctrl;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       hazard = 1'b0;
    logic       branch_taken_x = 1'b0;
    logic       md_start_x = 1'b0;
    logic       md_ready = 1'b0;
    logic       pc_en, fd_en, fd_flush, dx_bubble, dx_en, xm_bubble, md_go;
    logic       md_timeout;
    logic [3:0] stall_cnt, flush_cnt;

    pipeline_stall_ctrl #(.MD_TIMEOUT(8), .CNT_W(4)) dut (
        .clock(clock), .reset_n(reset_n), .hazard(hazard),
        .branch_taken_x(branch_taken_x), .md_start_x(md_start_x),
        .md_ready(md_ready), .pc_en(pc_en), .fd_en(fd_en),
        .fd_flush(fd_flush), .dx_bubble(dx_bubble), .dx_en(dx_en),
        .xm_bubble(xm_bubble), .md_go(md_go), .md_timeout(md_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit [6:0] outs;
        int       sc;
        int       fc;
        bit       tmo;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail = 0;

    // Reference model: waiting flag, MD_WAIT cycles already spent, guard, counters.
    bit   m_wait, m_guard, m_tmo;
    int   m_wcnt, m_stall, m_flush;

    function automatic bit [6:0] outs_now();
        return {pc_en, fd_en, fd_flush, dx_bubble, dx_en, xm_bubble, md_go};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wait = 0; m_guard = 0; m_tmo = 0;
        m_wcnt = 0; m_stall = 0; m_flush = 0;
    endtask

    // Called at posedge+1; drives one cycle, checks at the following negedge.
    task automatic step(input bit h, input bit b, input bit ms, input bit mr);
        exp_t     e;
        bit [6:0] o;
        bit       fl;
        hazard = h; branch_taken_x = b; md_start_x = ms; md_ready = mr;
        fl = 0;
        // bit order: pc fd flush bubble dx xm go
        if (!m_wait) begin
            if (ms && !m_guard)  o = 7'b0000011;
            else if (b) begin    o = 7'b1111100; fl = 1; end
            else if (h)          o = 7'b0001100;
            else                 o = 7'b1100100;
        end else begin
            o = mr ? 7'b0000000 : 7'b0000010;
        end
        e.outs = o; e.sc = m_stall; e.fc = m_flush; e.tmo = m_tmo;
        sbq.push_back(e);
        if (!o[6] && m_stall != 15) m_stall++;
        if (fl && m_flush != 15) m_flush++;
        if (!m_wait) begin
            if (ms && !m_guard) begin m_wait = 1; m_wcnt = 0; end
            m_guard = 0;
        end else if (mr) begin
            m_wait = 0; m_guard = 1;
        end else if (m_wcnt == 7) begin
            m_wait = 0; m_guard = 1; m_tmo = 1;
        end else begin
            m_wcnt++;
        end
        @(negedge clock);
        e = sbq.pop_front();
        check("outs", 32'(outs_now()), 32'(e.outs));
        check("stall_cnt", 32'(stall_cnt), e.sc);
        check("flush_cnt", 32'(flush_cnt), e.fc);
        check("md_timeout", 32'(md_timeout), 32'(e.tmo));
        @(posedge clock); #1;
    endtask

    task automatic do_reset(input bit h);
        reset_n = 1'b0;
        hazard = h; branch_taken_x = 0; md_start_x = 0; md_ready = 0;
        model_reset();
        #1;
        check("rst_outs", 32'(outs_now()), 32'(7'b0011010));
        @(posedge clock); #1;
        reset_n = 1'b1;
        hazard = 0;
        check("rst_stall", 32'(stall_cnt), 0);
        check("rst_flush", 32'(flush_cnt), 0);
        check("rst_tmo", 32'(md_timeout), 0);
    endtask

    initial begin
        do_reset(0);

        // Single-cycle load-use stall
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check("lu_stall", 32'(stall_cnt), 1);

        // Branch and hazard together: branch wins
        do_reset(0);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        check("br_flush", 32'(flush_cnt), 1);
        check("br_stall", 32'(stall_cnt), 0);

        // Multdiv held, ready in cycle 5, guard blocks re-issue in cycle 6
        do_reset(0);
        for (int c = 0; c <= 6; c++) step(0, 0, 1, c == 5);
        check("md_stall", 32'(stall_cnt), 6);
        step(0, 0, 0, 0);

        // Timeout after 8 MD_WAIT cycles; sticky afterwards
        do_reset(0);
        step(0, 0, 1, 0);
        for (int c = 0; c < 8; c++) step(0, 0, 0, 0);
        check("tmo_set", 32'(md_timeout), 1);
        for (int c = 0; c < 3; c++) step(0, 0, 0, 1);
        check("tmo_sticky", 32'(md_timeout), 1);

        // Asynchronous reset in the middle of MD_WAIT with hazard high
        do_reset(0);
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        do_reset(1);
        step(0, 0, 0, 0);

        // Stall counter saturation
        do_reset(0);
        for (int c = 0; c < 20; c++) step(1, 0, 0, 0);
        check("sat_stall", 32'(stall_cnt), 15);
        step(0, 0, 0, 0);

        // Random mix
        do_reset(0);
        for (int c = 0; c < 300; c++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
